// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, stage
// indices and the per-stage {en, flush} control record.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2,
    ERROR    = 2'd3
  } state_t;

  localparam int NUM_STAGES = 5;
  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  typedef stage_ctrl_t [NUM_STAGES-1:0] pipe_ctrl_t;

  function automatic pipe_ctrl_t uniformCtrl(input logic en, input logic flush);
    pipe_ctrl_t c;
    for (int i = 0; i < NUM_STAGES; i++) begin
      c[i].en    = en;
      c[i].flush = flush;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: clear is sampled on the clock edge only, matching the synchronous reset used by the whole pipeline.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: Mealy enable/flush
// outputs per stage, memory-wait watchdog, halt, and performance counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t            state;
  logic [WAIT_W-1:0] waitCnt;
  pipe_ctrl_t        ctrl;
  logic              loadUse;
  logic              memBlocked;
  logic              watchdogHit;
  logic              squash;
  logic              stallInc;
  logic              unusedPcFlush;

  assign loadUse = ex_mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign memBlocked = !dmem_ready &&
                      (((state == RUN) && mem_req) || (state == MEM_WAIT));

  // The current not-ready cycle is the (waitCnt+1)-th in a row, or the first when still in RUN.
  assign watchdogHit = (state == RUN) ? (MAX_WAIT <= 1)
                                      : (waitCnt >= WAIT_W'(MAX_WAIT - 1));

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    ctrl   = uniformCtrl(1'b1, 1'b0);
    squash = 1'b0;
    if (rst) begin
      ctrl = uniformCtrl(1'b0, 1'b1);
    end else begin
      unique case (state)
        RUN, MEM_WAIT: begin
          if (wb_halt || memBlocked) begin
            ctrl = uniformCtrl(1'b0, 1'b0);
            ctrl[STG_MEM_WB].flush = 1'b1;
          end else if (ex_branch_taken) begin
            ctrl[STG_IF_ID].flush = 1'b1;
            ctrl[STG_ID_EX].flush = 1'b1;
            squash = 1'b1;
          end else if (loadUse) begin
            ctrl[STG_PC].en       = 1'b0;
            ctrl[STG_IF_ID].en    = 1'b0;
            ctrl[STG_ID_EX].flush = 1'b1;
          end
        end
        default: ctrl = uniformCtrl(1'b0, 1'b0);
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      waitCnt <= '0;
    end else begin
      unique case (state)
        RUN, MEM_WAIT: begin
          if (wb_halt) begin
            state   <= HALTED;
            waitCnt <= '0;
          end else if (memBlocked) begin
            state   <= watchdogHit ? ERROR : MEM_WAIT;
            waitCnt <= (state == RUN) ? WAIT_W'(1) : waitCnt + 1'b1;
          end else begin
            state   <= RUN;
            waitCnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_en         = ctrl[STG_PC].en;
  assign if_id_en      = ctrl[STG_IF_ID].en;
  assign id_ex_en      = ctrl[STG_ID_EX].en;
  assign ex_mem_en     = ctrl[STG_EX_MEM].en;
  assign mem_wb_en     = ctrl[STG_MEM_WB].en;
  assign if_id_flush   = ctrl[STG_IF_ID].flush;
  assign id_ex_flush   = ctrl[STG_ID_EX].flush;
  assign ex_mem_flush  = ctrl[STG_EX_MEM].flush;
  assign mem_wb_flush  = ctrl[STG_MEM_WB].flush;
  assign unusedPcFlush = ctrl[STG_PC].flush;

  assign halted = !rst && (state == HALTED);
  assign err    = !rst && (state == ERROR);

  assign stallInc = ((state == RUN) || (state == MEM_WAIT)) && !ctrl[STG_PC].en;

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk  (clk),
    .clr  (rst),
    .inc  (stallInc),
    .count(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk  (clk),
    .clr  (rst),
    .inc  (squash),
    .count(flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: single-cycle RUN vectors from a table,
// then hand-written multi-cycle sequences (mem wait, halt, watchdog, reset).
module tb_pipeline_ctrl;

  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 4;

  logic             clk;
  logic             rst;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_mem_read, ex_branch_taken;
  logic             mem_req, dmem_ready, wb_halt;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic             halted, err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .dmem_ready(dmem_ready), .wb_halt(wb_halt),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .halted(halted), .err(err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       usesRt, memRead;
    logic [4:0] exRt;
    logic       branch, memReq, ready;
    logic [4:0] en;   // {mem_wb, ex_mem, id_ex, if_id, pc}
    logic [3:0] fl;   // {mem_wb, ex_mem, id_ex, if_id}
  } vec_t;

  function automatic vec_t mkVec(input string name, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic usesRt, input logic memRead, input logic [4:0] exRt,
                                 input logic branch, input logic memReq, input logic ready,
                                 input logic [4:0] en, input logic [3:0] fl);
    vec_t v;
    v.name = name; v.rs = rs; v.rt = rt; v.usesRt = usesRt; v.memRead = memRead;
    v.exRt = exRt; v.branch = branch; v.memReq = memReq; v.ready = ready;
    v.en = en; v.fl = fl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkCtrl(input string name, input logic [4:0] en, input logic [3:0] fl);
    check({name, " en"}, 32'({mem_wb_en, ex_mem_en, id_ex_en, if_id_en, pc_en}), 32'(en));
    check({name, " flush"}, 32'({mem_wb_flush, ex_mem_flush, id_ex_flush, if_id_flush}), 32'(fl));
  endtask

  task automatic idleInputs();
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_rt = '0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0; wb_halt = 1'b0;
  endtask

  // Leaves the DUT out of reset at a negedge with idle inputs.
  task automatic doReset(input string name);
    @(negedge clk);
    idleInputs();
    rst = 1'b1;
    #1;
    checkCtrl({name, " rst"}, 5'b00000, 4'b1111);
    check({name, " rst halted"}, 32'(halted), 32'd0);
    check({name, " rst err"}, 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check({name, " stall_cnt after rst"}, 32'(stall_cnt), 32'd0);
    check({name, " flush_cnt after rst"}, 32'(flush_cnt), 32'd0);
    #1;
  endtask

  vec_t vecs[10];
  int   expStall;
  int   expFlush;

  initial begin
    rst = 1'b1;
    idleInputs();

    vecs[0] = mkVec("idle",          5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000);
    vecs[1] = mkVec("lu rs",         5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 5'b11100, 4'b0010);
    vecs[2] = mkVec("lu rt",         5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 5'b11100, 4'b0010);
    vecs[3] = mkVec("rt no use",     5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000);
    vecs[4] = mkVec("r0 load",       5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000);
    vecs[5] = mkVec("not a load",    5'd8, 5'd8, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000);
    vecs[6] = mkVec("branch",        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'b11111, 4'b0011);
    vecs[7] = mkVec("branch+lu",     5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 5'b11111, 4'b0011);
    vecs[8] = mkVec("mem ready",     5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b11111, 4'b0000);
    vecs[9] = mkVec("mem ready+lu",  5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b1, 5'b11100, 4'b0010);

    // Table: every vector keeps the FSM in RUN, so each is a one-cycle check.
    doReset("table");
    expStall = 0;
    expFlush = 0;
    foreach (vecs[i]) begin
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].usesRt;
      ex_mem_read = vecs[i].memRead; ex_rt = vecs[i].exRt;
      ex_branch_taken = vecs[i].branch; mem_req = vecs[i].memReq; dmem_ready = vecs[i].ready;
      #1;
      checkCtrl(vecs[i].name, vecs[i].en, vecs[i].fl);
      if (!vecs[i].en[0]) expStall++;
      if (vecs[i].fl[0]) expFlush++;
      @(negedge clk);
    end
    idleInputs();
    #1;
    check("table stall_cnt", 32'(stall_cnt), 32'(expStall));
    check("table flush_cnt", 32'(flush_cnt), 32'(expFlush));

    // One-cycle load-use stall, then the load has moved on.
    doReset("lu");
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    checkCtrl("lu stall", 5'b11100, 4'b0010);
    @(negedge clk);
    ex_mem_read = 1'b0;
    #1;
    checkCtrl("lu after", 5'b11111, 4'b0000);
    check("lu stall_cnt", 32'(stall_cnt), 32'd1);

    // Three not-ready cycles, then ready: three stalls and back to RUN.
    doReset("mw");
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkCtrl($sformatf("mw wait%0d", i), 5'b00000, 4'b1000);
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    #1;
    checkCtrl("mw ready", 5'b11111, 4'b0000);
    @(negedge clk);
    mem_req = 1'b0; dmem_ready = 1'b0;
    #1;
    checkCtrl("mw back in run", 5'b11111, 4'b0000);
    check("mw stall_cnt", 32'(stall_cnt), 32'd3);
    check("mw err", 32'(err), 32'd0);

    // Branch together with load-use: squash only, no stall.
    doReset("br");
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #1;
    checkCtrl("br+lu", 5'b11111, 4'b0011);
    @(negedge clk);
    idleInputs();
    #1;
    check("br flush_cnt", 32'(flush_cnt), 32'd1);
    check("br stall_cnt", 32'(stall_cnt), 32'd0);

    // Halt arriving during MEM_WAIT; HALTED is sticky until reset.
    doReset("halt");
    mem_req = 1'b1;
    #1;
    @(negedge clk);
    wb_halt = 1'b1;
    #1;
    checkCtrl("halt cycle", 5'b00000, 4'b1000);
    check("halt cycle halted", 32'(halted), 32'd0);
    @(negedge clk);
    idleInputs();
    dmem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("halted %0d", i), 32'(halted), 32'd1);
      checkCtrl($sformatf("halted %0d", i), 5'b00000, 4'b0000);
      @(negedge clk);
    end
    #1;
    check("halt stall_cnt", 32'(stall_cnt), 32'd2);
    doReset("after halt");
    #1;
    check("after halt halted", 32'(halted), 32'd0);
    checkCtrl("after halt run", 5'b11111, 4'b0000);

    // Watchdog: err after MAX_WAIT consecutive not-ready cycles, sticky.
    doReset("wd");
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      #1;
      check($sformatf("wd err low %0d", i), 32'(err), 32'd0);
      @(negedge clk);
    end
    #1;
    check("wd err", 32'(err), 32'd1);
    checkCtrl("wd error", 5'b00000, 4'b0000);
    @(negedge clk);
    mem_req = 1'b0; dmem_ready = 1'b1;
    #1;
    check("wd err sticky", 32'(err), 32'd1);
    doReset("after wd");
    #1;
    check("after wd err", 32'(err), 32'd0);

    // Reset in MEM_WAIT wins over a same-cycle dmem_ready.
    doReset("rmw");
    mem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1; dmem_ready = 1'b1;
    #1;
    checkCtrl("rmw rst", 5'b00000, 4'b1111);
    @(negedge clk);
    rst = 1'b0;
    idleInputs();
    #1;
    checkCtrl("rmw run", 5'b11111, 4'b0000);
    check("rmw stall_cnt", 32'(stall_cnt), 32'd0);

    // Counter saturation at all-ones.
    doReset("sat");
    ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7;
    repeat (20) @(negedge clk);
    #1;
    check("sat stall_cnt", 32'(stall_cnt), 32'((1 << CNT_W) - 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
